rob_commit: RTL and testbench

ROB_COMMIT -- requirements
Module: rob_commit

---
 rtl/rob_commit.sv | 151 +++++++++++++++
 tb/tb_rob_commit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// 64-entry reorder buffer: 4-wide allocate, 4 completion buses, 2-wide in-order retire.
// Optional flush port is enabled by defining ROB_COMMIT_FLUSH_EN.
module rob_commit (
    input  logic        clk,
    input  logic        rst,
`ifdef ROB_COMMIT_FLUSH_EN
    input  logic        flush,
`endif
    input  logic [2:0]  alloc_count,
    input  logic [3:0]  alloc_wreg,
    input  logic [11:0] alloc_dst,
    input  logic [63:0] alloc_pc,
    output logic        alloc_ready,
    output logic [5:0]  alloc_tail,
    input  logic [22:0] fwd_a,
    input  logic [22:0] fwd_b,
    input  logic [22:0] fwd_c,
    input  logic [22:0] fwd_d,
    output logic        wen0,
    output logic        wen1,
    output logic [2:0]  waddr0,
    output logic [2:0]  waddr1,
    output logic [15:0] wdata0,
    output logic [15:0] wdata1,
    output logic [1:0]  retire_count,
    output logic [6:0]  rob_count
);

    logic [63:0] occ;
    logic [63:0] rdy;
    logic [15:0] valMem  [64];
    logic [15:0] pcMem   [64];
    logic        wregMem [64];
    logic [2:0]  dstMem  [64];

    logic [5:0]  head;
    logic [5:0]  tail;
    logic [5:0]  headNext1;
    logic        ret0;
    logic        ret1;
    logic [1:0]  retN;
    logic        sameDst;
    logic        doAlloc;
    logic [5:0]  allocIdx [4];
    logic [22:0] fwdBus   [4];

    assign alloc_ready = (rob_count <= 7'd60);
    assign alloc_tail  = tail;

    always_comb begin
        headNext1 = head + 6'd1;
        ret0      = occ[head] & rdy[head];
        ret1      = ret0 & occ[headNext1] & rdy[headNext1];
        retN      = {1'b0, ret0} + {1'b0, ret1};
        sameDst   = wregMem[head] & wregMem[headNext1] & (dstMem[head] == dstMem[headNext1]);
        doAlloc   = (alloc_count != 3'd0) && alloc_ready;
        for (int unsigned i = 0; i < 4; i++) begin
            allocIdx[i] = tail + 6'(i);
        end
        fwdBus[0] = fwd_a;
        fwdBus[1] = fwd_b;
        fwdBus[2] = fwd_c;
        fwdBus[3] = fwd_d;
    end

    // Buses are applied lowest priority first so fwd_a's assignment lands last and wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ          <= '0;
            rdy          <= '0;
            head         <= '0;
            tail         <= '0;
            rob_count    <= '0;
            wen0         <= 1'b0;
            wen1         <= 1'b0;
            waddr0       <= '0;
            waddr1       <= '0;
            wdata0       <= '0;
            wdata1       <= '0;
            retire_count <= '0;
`ifdef ROB_COMMIT_FLUSH_EN
        end else if (flush) begin
            occ          <= '0;
            rdy          <= '0;
            head         <= '0;
            tail         <= '0;
            rob_count    <= '0;
            wen0         <= 1'b0;
            wen1         <= 1'b0;
            waddr0       <= '0;
            waddr1       <= '0;
            wdata0       <= '0;
            wdata1       <= '0;
            retire_count <= '0;
`endif
        end else begin
            for (int unsigned j = 0; j < 4; j++) begin
                if (fwdBus[3 - j][22] && occ[fwdBus[3 - j][21:16]]) begin
                    rdy[fwdBus[3 - j][21:16]] <= 1'b1;
                end
            end
            if (doAlloc) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (3'(i) < alloc_count) begin
                        occ[allocIdx[i]] <= 1'b1;
                        rdy[allocIdx[i]] <= 1'b0;
                    end
                end
                tail <= tail + {3'b000, alloc_count};
            end
            if (ret0) begin
                occ[head] <= 1'b0;
                rdy[head] <= 1'b0;
            end
            if (ret1) begin
                occ[headNext1] <= 1'b0;
                rdy[headNext1] <= 1'b0;
            end
            head      <= head + {4'b0000, retN};
            rob_count <= rob_count + (doAlloc ? {4'b0000, alloc_count} : 7'd0) - {5'b00000, retN};

            // Same-register pair: drop the older write so the younger value is the one kept.
            wen0         <= ret0 & wregMem[head] & ~(ret1 & sameDst);
            wen1         <= ret1 & wregMem[headNext1];
            waddr0       <= ret0 ? dstMem[head] : 3'd0;
            waddr1       <= ret1 ? dstMem[headNext1] : 3'd0;
            wdata0       <= ret0 ? valMem[head] : 16'd0;
            wdata1       <= ret1 ? valMem[headNext1] : 16'd0;
            retire_count <= retN;
        end
    end

    // Payload storage needs no reset; occupancy bits gate every use of it.
    always_ff @(posedge clk) begin
        for (int unsigned j = 0; j < 4; j++) begin
            if (fwdBus[3 - j][22] && occ[fwdBus[3 - j][21:16]]) begin
                valMem[fwdBus[3 - j][21:16]] <= fwdBus[3 - j][15:0];
            end
        end
        if (doAlloc) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (3'(i) < alloc_count) begin
                    wregMem[allocIdx[i]] <= alloc_wreg[3 - i];
                    dstMem[allocIdx[i]]  <= alloc_dst[11 - 3 * i -: 3];
                    pcMem[allocIdx[i]]   <= alloc_pc[63 - 16 * i -: 16];
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Directed self-checking bench for rob_commit; covers the flush port when ROB_COMMIT_FLUSH_EN is defined.
module tb_rob_commit;

    logic        clk = 1'b0;
    logic        rst;
`ifdef ROB_COMMIT_FLUSH_EN
    logic        flush;
`endif
    logic [2:0]  alloc_count;
    logic [3:0]  alloc_wreg;
    logic [11:0] alloc_dst;
    logic [63:0] alloc_pc;
    logic        alloc_ready;
    logic [5:0]  alloc_tail;
    logic [22:0] fwd_a, fwd_b, fwd_c, fwd_d;
    logic        wen0, wen1;
    logic [2:0]  waddr0, waddr1;
    logic [15:0] wdata0, wdata1;
    logic [1:0]  retire_count;
    logic [6:0]  rob_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rob_commit dut (
        .clk(clk),
        .rst(rst),
`ifdef ROB_COMMIT_FLUSH_EN
        .flush(flush),
`endif
        .alloc_count(alloc_count),
        .alloc_wreg(alloc_wreg),
        .alloc_dst(alloc_dst),
        .alloc_pc(alloc_pc),
        .alloc_ready(alloc_ready),
        .alloc_tail(alloc_tail),
        .fwd_a(fwd_a),
        .fwd_b(fwd_b),
        .fwd_c(fwd_c),
        .fwd_d(fwd_d),
        .wen0(wen0),
        .wen1(wen1),
        .waddr0(waddr0),
        .waddr1(waddr1),
        .wdata0(wdata0),
        .wdata1(wdata1),
        .retire_count(retire_count),
        .rob_count(rob_count)
    );

    function automatic logic [22:0] fw(input logic [5:0] idx, input logic [15:0] d);
        return {1'b1, idx, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        alloc_count = '0;
        alloc_wreg  = '0;
        alloc_dst   = '0;
        alloc_pc    = '0;
        fwd_a = '0;
        fwd_b = '0;
        fwd_c = '0;
        fwd_d = '0;
`ifdef ROB_COMMIT_FLUSH_EN
        flush = 1'b0;
`endif
    endtask

    task automatic doReset();
        rst = 1'b1;
        clearInputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clearInputs();
        alloc_count = 3'd4;
        tick();
        tick();
        checks++; if (rob_count !== 7'd0) begin errors++; $display("FAIL reset_count got %0d want 0", rob_count); end
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", alloc_ready); end
        checks++; if (alloc_tail !== 6'd0) begin errors++; $display("FAIL reset_tail got %0d want 0", alloc_tail); end
        checks++; if ({wen0, wen1, retire_count} !== 4'b0000) begin errors++;
            $display("FAIL reset_wen got wen0=%0b wen1=%0b rc=%0d want 0 0 0", wen0, wen1, retire_count); end
        checks++; if ({waddr0, waddr1, wdata0, wdata1} !== 38'd0) begin errors++;
            $display("FAIL reset_wbus got %0d %0d %h %h want 0 0 0 0", waddr0, waddr1, wdata0, wdata1); end
        clearInputs();
        rst = 1'b0;
    endtask

    task automatic test_single_retire();
        doReset();
        alloc_count = 3'd4;
        alloc_wreg  = 4'b1111;
        alloc_dst   = {3'd1, 3'd2, 3'd3, 3'd4};
        alloc_pc    = {16'h0100, 16'h0102, 16'h0104, 16'h0106};
        tick();
        clearInputs();
        checks++; if (rob_count !== 7'd4 || alloc_tail !== 6'd4) begin errors++;
            $display("FAIL alloc4 got count=%0d tail=%0d want 4 4", rob_count, alloc_tail); end
        fwd_a = fw(6'd0, 16'h1234);
        tick();
        fwd_a = '0;
        checks++; if (retire_count !== 2'd0 || wen0 !== 1'b0) begin errors++;
            $display("FAIL capture_edge got rc=%0d wen0=%0b want 0 0", retire_count, wen0); end
        tick();
        checks++; if (wen0 !== 1'b1 || waddr0 !== 3'd1 || wdata0 !== 16'h1234 || wen1 !== 1'b0) begin errors++;
            $display("FAIL single_wb got wen0=%0b a=%0d d=%h wen1=%0b want 1 1 1234 0", wen0, waddr0, wdata0, wen1); end
        checks++; if (retire_count !== 2'd1 || rob_count !== 7'd3) begin errors++;
            $display("FAIL single_cnt got rc=%0d count=%0d want 1 3", retire_count, rob_count); end
        tick();
        checks++; if (wen0 !== 1'b0 || retire_count !== 2'd0) begin errors++;
            $display("FAIL single_idle got wen0=%0b rc=%0d want 0 0", wen0, retire_count); end
    endtask

    task automatic test_dual_retire();
        doReset();
        alloc_count = 3'd4;
        alloc_wreg  = 4'b1111;
        alloc_dst   = {3'd1, 3'd2, 3'd3, 3'd4};
        tick();
        clearInputs();
        fwd_a = fw(6'd0, 16'h5555);
        fwd_b = fw(6'd1, 16'hAAAA);
        tick();
        clearInputs();
        tick();
        checks++; if (wen0 !== 1'b1 || waddr0 !== 3'd1 || wdata0 !== 16'h5555) begin errors++;
            $display("FAIL dual_p0 got wen0=%0b a=%0d d=%h want 1 1 5555", wen0, waddr0, wdata0); end
        checks++; if (wen1 !== 1'b1 || waddr1 !== 3'd2 || wdata1 !== 16'hAAAA) begin errors++;
            $display("FAIL dual_p1 got wen1=%0b a=%0d d=%h want 1 2 aaaa", wen1, waddr1, wdata1); end
        checks++; if (retire_count !== 2'd2 || rob_count !== 7'd2) begin errors++;
            $display("FAIL dual_cnt got rc=%0d count=%0d want 2 2", retire_count, rob_count); end
    endtask

    task automatic test_in_order();
        doReset();
        alloc_count = 3'd4;
        alloc_wreg  = 4'b1111;
        alloc_dst   = {3'd1, 3'd2, 3'd3, 3'd4};
        tick();
        clearInputs();
        fwd_a = fw(6'd0, 16'h0F0F);
        tick();
        clearInputs();
        tick();
        fwd_c = fw(6'd2, 16'h2222);
        tick();
        clearInputs();
        tick();
        checks++; if (retire_count !== 2'd0 || wen0 !== 1'b0 || rob_count !== 7'd3) begin errors++;
            $display("FAIL blocked_head got rc=%0d wen0=%0b count=%0d want 0 0 3", retire_count, wen0, rob_count); end
        fwd_d = fw(6'd1, 16'h1111);
        tick();
        clearInputs();
        tick();
        checks++; if (retire_count !== 2'd2 || wdata0 !== 16'h1111 || wdata1 !== 16'h2222) begin errors++;
            $display("FAIL unblock got rc=%0d d0=%h d1=%h want 2 1111 2222", retire_count, wdata0, wdata1); end
        // Entry 3 remains; a and b race on it, a must win. c targets an unoccupied index.
        fwd_b = fw(6'd3, 16'hBBBB);
        fwd_a = fw(6'd3, 16'hAAAA);
        fwd_c = fw(6'd9, 16'hCCCC);
        tick();
        clearInputs();
        tick();
        checks++; if (retire_count !== 2'd1 || waddr0 !== 3'd4 || wdata0 !== 16'hAAAA || rob_count !== 7'd0) begin errors++;
            $display("FAIL priority got rc=%0d a=%0d d=%h count=%0d want 1 4 aaaa 0", retire_count, waddr0, wdata0, rob_count); end
    endtask

    task automatic test_full();
        doReset();
        alloc_count = 3'd4;
        repeat (15) tick();
        checks++; if (rob_count !== 7'd60 || alloc_ready !== 1'b1) begin errors++;
            $display("FAIL at60 got count=%0d ready=%0b want 60 1", rob_count, alloc_ready); end
        alloc_count = 3'd1;
        tick();
        checks++; if (rob_count !== 7'd61 || alloc_ready !== 1'b0) begin errors++;
            $display("FAIL at61 got count=%0d ready=%0b want 61 0", rob_count, alloc_ready); end
        alloc_count = 3'd4;
        tick();
        clearInputs();
        checks++; if (rob_count !== 7'd61 || alloc_tail !== 6'd61) begin errors++;
            $display("FAIL ignored got count=%0d tail=%0d want 61 61", rob_count, alloc_tail); end
    endtask

    task automatic test_wrap();
        doReset();
        alloc_count = 3'd4;
        repeat (15) tick();
        alloc_count = 3'd3;
        tick();
        clearInputs();
        for (int c = 0; c < 16; c++) begin
            fwd_a = fw(6'(4 * c), 16'h0);
            fwd_b = fw(6'(4 * c + 1), 16'h0);
            fwd_c = fw(6'(4 * c + 2), 16'h0);
            fwd_d = (c < 15) ? fw(6'(4 * c + 3), 16'h0) : 23'd0;
            tick();
        end
        clearInputs();
        repeat (40) tick();
        checks++; if (rob_count !== 7'd0 || alloc_tail !== 6'd63) begin errors++;
            $display("FAIL drain got count=%0d tail=%0d want 0 63", rob_count, alloc_tail); end
        alloc_count = 3'd2;
        alloc_wreg  = 4'b1100;
        alloc_dst   = {3'd6, 3'd7, 6'd0};
        tick();
        clearInputs();
        fwd_a = fw(6'd63, 16'h6363);
        fwd_b = fw(6'd0, 16'h0A0A);
        tick();
        clearInputs();
        tick();
        checks++; if (retire_count !== 2'd2 || wen0 !== 1'b1 || waddr0 !== 3'd6 || wdata0 !== 16'h6363) begin errors++;
            $display("FAIL wrap_p0 got rc=%0d wen0=%0b a=%0d d=%h want 2 1 6 6363", retire_count, wen0, waddr0, wdata0); end
        checks++; if (wen1 !== 1'b1 || waddr1 !== 3'd7 || wdata1 !== 16'h0A0A || alloc_tail !== 6'd1) begin errors++;
            $display("FAIL wrap_p1 got wen1=%0b a=%0d d=%h tail=%0d want 1 7 0a0a 1", wen1, waddr1, wdata1, alloc_tail); end
        alloc_count = 3'd1;
        alloc_wreg  = 4'b1000;
        alloc_dst   = {3'd2, 9'd0};
        tick();
        clearInputs();
        fwd_a = fw(6'd1, 16'h0101);
        tick();
        clearInputs();
        tick();
        checks++; if (retire_count !== 2'd1 || wen0 !== 1'b1 || waddr0 !== 3'd2 || wdata0 !== 16'h0101) begin errors++;
            $display("FAIL head_at1 got rc=%0d wen0=%0b a=%0d d=%h want 1 1 2 0101", retire_count, wen0, waddr0, wdata0); end
    endtask

    task automatic test_same_reg();
        doReset();
        alloc_count = 3'd2;
        alloc_wreg  = 4'b1100;
        alloc_dst   = {3'd5, 3'd5, 6'd0};
        tick();
        clearInputs();
        fwd_a = fw(6'd0, 16'd7);
        fwd_b = fw(6'd1, 16'd9);
        tick();
        clearInputs();
        tick();
        checks++; if (wen0 !== 1'b0 || wen1 !== 1'b1 || waddr1 !== 3'd5 || wdata1 !== 16'd9) begin errors++;
            $display("FAIL same_reg got wen0=%0b wen1=%0b a1=%0d d1=%0d want 0 1 5 9", wen0, wen1, waddr1, wdata1); end
        checks++; if (retire_count !== 2'd2) begin errors++;
            $display("FAIL same_reg_rc got %0d want 2", retire_count); end
    endtask

    task automatic test_midflight_reset();
        doReset();
        alloc_count = 3'd2;
        alloc_wreg  = 4'b1100;
        alloc_dst   = {3'd3, 3'd4, 6'd0};
        tick();
        clearInputs();
        fwd_a = fw(6'd0, 16'h3333);
        fwd_b = fw(6'd1, 16'h4444);
        tick();
        clearInputs();
        #2 rst = 1'b1;
        #1;
        checks++; if (rob_count !== 7'd0 || alloc_ready !== 1'b1) begin errors++;
            $display("FAIL async_rst got count=%0d ready=%0b want 0 1", rob_count, alloc_ready); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (wen0 !== 1'b0 || wen1 !== 1'b0 || retire_count !== 2'd0 || rob_count !== 7'd0) begin errors++;
            $display("FAIL post_rst got wen0=%0b wen1=%0b rc=%0d count=%0d want 0 0 0 0", wen0, wen1, retire_count, rob_count); end
    endtask

`ifdef ROB_COMMIT_FLUSH_EN
    task automatic test_flush();
        doReset();
        alloc_count = 3'd2;
        alloc_wreg  = 4'b1100;
        alloc_dst   = {3'd5, 3'd6, 6'd0};
        tick();
        clearInputs();
        fwd_a = fw(6'd0, 16'h0007);
        fwd_b = fw(6'd1, 16'h0009);
        tick();
        clearInputs();
        flush = 1'b1;
        alloc_count = 3'd4;
        tick();
        clearInputs();
        checks++; if (rob_count !== 7'd0 || alloc_tail !== 6'd0) begin errors++;
            $display("FAIL flush_cnt got count=%0d tail=%0d want 0 0", rob_count, alloc_tail); end
        checks++; if (wen0 !== 1'b0 || wen1 !== 1'b0 || retire_count !== 2'd0) begin errors++;
            $display("FAIL flush_wen got wen0=%0b wen1=%0b rc=%0d want 0 0 0", wen0, wen1, retire_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_retire();
        test_dual_retire();
        test_in_order();
        test_full();
        test_wrap();
        test_same_reg();
        test_midflight_reset();
`ifdef ROB_COMMIT_FLUSH_EN
        test_flush();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
